// File: rtl/dip_lb_pkg.sv
// rtl/dip_lb_pkg.sv - shared types and constants for the DIP line-window blocks
package dip_lb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } lb_state_e;

    // Control bits that travel with a pixel through the read/write pipeline
    typedef struct packed {
        logic vld;
        logic emit;
        logic eol;
        logic eof;
    } stage_ctl_t;

    localparam int LB_LATENCY = 1;
    localparam int WIN_ROWS   = 3;
    localparam int FILL_ROWS  = WIN_ROWS - 1;

endpackage

// File: rtl/dip_raster_cnt.sv
// rtl/dip_raster_cnt.sv - raster column/row position tracker with line/frame end flags
module dip_raster_cnt #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int AW    = 10,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sof_i,
    input  logic          adv_i,
    output logic [AW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          eol_o,
    output logic          eof_o
);

    logic [AW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Outputs give the position of the pixel being presented; sof forces origin
    always_comb begin
        col_o = sof_i ? '0 : col_q;
        row_o = sof_i ? '0 : row_q;
        eol_o = (col_o == AW'(IMG_W - 1));
        eof_o = eol_o && (row_o == RW'(IMG_H - 1));
        col_d = col_q;
        row_d = row_q;
        if (adv_i) begin
            if (eof_o) begin
                col_d = '0;
                row_d = '0;
            end else if (eol_o) begin
                col_d = '0;
                row_d = row_o + 1'b1;
            end else begin
                col_d = col_o + 1'b1;
                row_d = row_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/linebuffer_1x640x8.sv
// rtl/linebuffer_1x640x8.sv - single-port line store, registered read-before-write
module linebuffer_1x640x8 #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic          wr_en,
    input  logic          rd_en,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (32'(addr) < DEPTH) begin
            if (rd_en) rdata <= mem[addr];
            if (wr_en) mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/dip_line_win3_ctrl.sv
// rtl/dip_line_win3_ctrl.sv - drives two line buffers as a 2-line delay, emits 3-row columns
module dip_line_win3_ctrl
    import dip_lb_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int DW    = 8,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic [DW-1:0] in_data,
    output logic [AW-1:0] lb0_addr,
    output logic          lb0_wr_en,
    output logic          lb0_rd_en,
    output logic [DW-1:0] lb0_wdata,
    input  logic [DW-1:0] lb0_rdata,
    output logic [AW-1:0] lb1_addr,
    output logic          lb1_wr_en,
    output logic          lb1_rd_en,
    output logic [DW-1:0] lb1_wdata,
    input  logic [DW-1:0] lb1_rdata,
    output logic          out_valid,
    output logic [DW-1:0] out_top,
    output logic [DW-1:0] out_mid,
    output logic [DW-1:0] out_bot,
    output logic [AW-1:0] out_col,
    output logic          out_eol,
    output logic          out_eof,
    output logic          ovf_err
);

    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    lb_state_e     state_q, state_d;
    logic          sof_v;
    logic          acc;
    logic          ovf_d, ovf_q;
    logic [AW-1:0] pos_col;
    logic [RW-1:0] pos_row;
    logic          pos_eol, pos_eof;

    stage_ctl_t    s0_ctl, s1_q, s2_q;
    logic [AW-1:0] s1_col_q, s2_col_q, col_out_q;
    logic [DW-1:0] s1_bot_q, s2_bot_q, s2_mid_q;
    logic [DW-1:0] top_q, mid_q, bot_q;
    logic          vld_q, eol_q, eof_q;

    assign sof_v = in_valid && in_sof && !rst;

    dip_raster_cnt #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .AW    (AW),
        .RW    (RW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .sof_i (sof_v),
        .adv_i (acc),
        .col_o (pos_col),
        .row_o (pos_row),
        .eol_o (pos_eol),
        .eof_o (pos_eof)
    );

    always_comb begin
        state_d = state_q;
        acc     = 1'b0;
        ovf_d   = 1'b0;
        if (!rst && in_valid) begin
            if (in_sof) begin
                acc     = 1'b1;
                state_d = ST_FILL;
            end else begin
                case (state_q)
                    ST_FILL: begin
                        acc = 1'b1;
                        if (pos_eol && pos_row == RW'(FILL_ROWS - 1)) state_d = ST_RUN;
                    end
                    ST_RUN: begin
                        acc = 1'b1;
                        if (pos_eof) state_d = ST_DONE;
                    end
                    ST_DONE: ovf_d = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        s0_ctl      = '0;
        s0_ctl.vld  = acc;
        s0_ctl.emit = acc && !in_sof && (state_q == ST_RUN);
        s0_ctl.eol  = pos_eol;
        s0_ctl.eof  = pos_eof;
    end

    // Idle stages keep their address but never write; s1_col_q is the last stage-0 column
    assign lb0_addr  = acc ? pos_col : s1_col_q;
    assign lb0_wr_en = acc;
    assign lb0_rd_en = !rst;
    assign lb0_wdata = acc ? in_data : '0;

    assign lb1_addr  = s1_col_q;
    assign lb1_wr_en = s1_q.vld;
    assign lb1_rd_en = !rst;
    assign lb1_wdata = s1_q.vld ? lb0_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ovf_q     <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            s1_col_q  <= '0;
            s2_col_q  <= '0;
            s1_bot_q  <= '0;
            s2_bot_q  <= '0;
            s2_mid_q  <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            col_out_q <= '0;
            vld_q     <= 1'b0;
            eol_q     <= 1'b0;
            eof_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            s1_q    <= s0_ctl;
            s2_q    <= s1_q;
            if (acc) begin
                s1_col_q <= pos_col;
                s1_bot_q <= in_data;
            end
            if (s1_q.vld) begin
                s2_col_q <= s1_col_q;
                s2_bot_q <= s1_bot_q;
                s2_mid_q <= lb0_rdata;
            end
            // lb1_rdata is valid in the cycle after stage 1, aligned with stage 2
            if (s2_q.vld) begin
                top_q     <= lb1_rdata;
                mid_q     <= s2_mid_q;
                bot_q     <= s2_bot_q;
                col_out_q <= s2_col_q;
            end
            vld_q <= s2_q.vld && s2_q.emit;
            eol_q <= s2_q.vld && s2_q.emit && s2_q.eol;
            eof_q <= s2_q.vld && s2_q.emit && s2_q.eof;
        end
    end

    assign out_valid = vld_q;
    assign out_top   = top_q;
    assign out_mid   = mid_q;
    assign out_bot   = bot_q;
    assign out_col   = col_out_q;
    assign out_eol   = eol_q;
    assign out_eof   = eof_q;
    assign ovf_err   = ovf_q;

endmodule

// File: tb/tb_dip_line_win3_ctrl.sv
// tb/tb_dip_line_win3_ctrl.sv - directed bench: 640x4 and 8x3 geometries with line buffer models
module tb_dip_line_win3_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic       a_in_valid, a_in_sof, b_in_valid, b_in_sof;
    logic [7:0] a_in_data, b_in_data;
    logic [9:0] a_lb0_addr, a_lb1_addr, a_out_col, b_lb0_addr, b_lb1_addr, b_out_col;
    logic       a_lb0_wr_en, a_lb0_rd_en, a_lb1_wr_en, a_lb1_rd_en;
    logic       b_lb0_wr_en, b_lb0_rd_en, b_lb1_wr_en, b_lb1_rd_en;
    logic [7:0] a_lb0_wdata, a_lb0_rdata, a_lb1_wdata, a_lb1_rdata;
    logic [7:0] b_lb0_wdata, b_lb0_rdata, b_lb1_wdata, b_lb1_rdata;
    logic [7:0] a_out_top, a_out_mid, a_out_bot, b_out_top, b_out_mid, b_out_bot;
    logic       a_out_valid, a_out_eol, a_out_eof, a_ovf_err;
    logic       b_out_valid, b_out_eol, b_out_eof, b_ovf_err;

    dip_line_win3_ctrl #(.IMG_W(640), .IMG_H(4), .DW(8), .AW(10)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_sof(a_in_sof), .in_data(a_in_data),
        .lb0_addr(a_lb0_addr), .lb0_wr_en(a_lb0_wr_en), .lb0_rd_en(a_lb0_rd_en),
        .lb0_wdata(a_lb0_wdata), .lb0_rdata(a_lb0_rdata),
        .lb1_addr(a_lb1_addr), .lb1_wr_en(a_lb1_wr_en), .lb1_rd_en(a_lb1_rd_en),
        .lb1_wdata(a_lb1_wdata), .lb1_rdata(a_lb1_rdata),
        .out_valid(a_out_valid), .out_top(a_out_top), .out_mid(a_out_mid),
        .out_bot(a_out_bot), .out_col(a_out_col), .out_eol(a_out_eol),
        .out_eof(a_out_eof), .ovf_err(a_ovf_err)
    );

    dip_line_win3_ctrl #(.IMG_W(8), .IMG_H(3), .DW(8), .AW(10)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_sof(b_in_sof), .in_data(b_in_data),
        .lb0_addr(b_lb0_addr), .lb0_wr_en(b_lb0_wr_en), .lb0_rd_en(b_lb0_rd_en),
        .lb0_wdata(b_lb0_wdata), .lb0_rdata(b_lb0_rdata),
        .lb1_addr(b_lb1_addr), .lb1_wr_en(b_lb1_wr_en), .lb1_rd_en(b_lb1_rd_en),
        .lb1_wdata(b_lb1_wdata), .lb1_rdata(b_lb1_rdata),
        .out_valid(b_out_valid), .out_top(b_out_top), .out_mid(b_out_mid),
        .out_bot(b_out_bot), .out_col(b_out_col), .out_eol(b_out_eol),
        .out_eof(b_out_eof), .ovf_err(b_ovf_err)
    );

    linebuffer_1x640x8 u_a_lb0 (.clk(clk), .addr(a_lb0_addr), .wr_en(a_lb0_wr_en),
        .rd_en(a_lb0_rd_en), .wdata(a_lb0_wdata), .rdata(a_lb0_rdata));
    linebuffer_1x640x8 u_a_lb1 (.clk(clk), .addr(a_lb1_addr), .wr_en(a_lb1_wr_en),
        .rd_en(a_lb1_rd_en), .wdata(a_lb1_wdata), .rdata(a_lb1_rdata));
    linebuffer_1x640x8 u_b_lb0 (.clk(clk), .addr(b_lb0_addr), .wr_en(b_lb0_wr_en),
        .rd_en(b_lb0_rd_en), .wdata(b_lb0_wdata), .rdata(b_lb0_rdata));
    linebuffer_1x640x8 u_b_lb1 (.clk(clk), .addr(b_lb1_addr), .wr_en(b_lb1_wr_en),
        .rd_en(b_lb1_rd_en), .wdata(b_lb1_wdata), .rdata(b_lb1_rdata));

    logic [33:0] a_obs[$];
    logic [35:0] b_obs[$];
    int a_first = -1;
    int a_acc   = -1;
    int idle_wr = 0;

    always @(negedge clk) begin
        if (a_out_valid) begin
            if (a_first < 0) a_first = cyc;
            a_obs.push_back({a_out_top, a_out_mid, a_out_bot, a_out_col});
        end
        if (b_out_valid)
            b_obs.push_back({b_out_top, b_out_mid, b_out_bot, b_out_col, b_out_eol, b_out_eof});
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic px(input bit sel_b, input logic sof, input logic [7:0] d);
        if (sel_b) begin
            b_in_valid = 1'b1; b_in_sof = sof; b_in_data = d;
        end else begin
            a_in_valid = 1'b1; a_in_sof = sof; a_in_data = d;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        a_in_valid = 1'b0; a_in_sof = 1'b0;
        b_in_valid = 1'b0; b_in_sof = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (a_lb0_wr_en || b_lb0_wr_en) idle_wr++;
            @(posedge clk); #1;
        end
    endtask

    task automatic frame(input bit sel_b, input int w, input int r0, input int r1,
                         input int last_cols, input logic [7:0] base, input bit gap);
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < ((r == r1) ? last_cols : w); c++) begin
                if (!sel_b && r == 2 && c == 0 && a_acc < 0) a_acc = cyc;
                px(sel_b, (r == 0 && c == 0), base + 8'(r * 16 + c));
                if (gap) idle(1);
            end
        end
    endtask

    function automatic logic [33:0] exp_a(input int r, input int c);
        return {8'((r - 2) * 16 + c), 8'((r - 1) * 16 + c), 8'(r * 16 + c), 10'(c)};
    endfunction

    function automatic logic [35:0] exp_b(input logic [7:0] base, input int c, input logic last);
        return {base + 8'(c), base + 8'(16 + c), base + 8'(32 + c), 10'(c), last, last};
    endfunction

    task automatic cmp_a(input string tag);
        chk({tag, "_count"}, a_obs.size(), 1280);
        for (int k = 0; k < 1280 && k < a_obs.size(); k++)
            chk(tag, a_obs[k], exp_a(2 + k / 640, k % 640));
    endtask

    initial begin
        rst = 1'b1;
        a_in_data = '0;
        b_in_data = '0;
        idle(0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_a_out", {a_out_valid, a_out_top, a_out_mid, a_out_bot, a_out_col,
                          a_out_eol, a_out_eof, a_ovf_err}, '0);
        chk("rst_a_lb", {a_lb0_addr, a_lb0_wr_en, a_lb0_rd_en, a_lb0_wdata,
                         a_lb1_addr, a_lb1_wr_en, a_lb1_rd_en, a_lb1_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // 640x4 frame, back-to-back pixels
        frame(1'b0, 640, 0, 3, 640, 8'h00, 1'b0);
        idle(5);
        chk("t1_latency", a_first - a_acc, 3);
        chk("t1_first", (a_obs.size() > 0) ? a_obs[0] : 34'd0, {8'h00, 8'h10, 8'h20, 10'd0});
        cmp_a("t1");

        // same frame with a gap after every pixel
        a_obs.delete();
        frame(1'b0, 640, 0, 3, 640, 8'h00, 1'b1);
        idle(5);
        cmp_a("t2");
        chk("t2_idle_wr", idle_wr, 0);

        // 8x3 frame: line/frame end flags, then overflow in DONE
        frame(1'b1, 8, 0, 2, 8, 8'h00, 1'b0);
        idle(5);
        chk("t3_count", b_obs.size(), 8);
        for (int c = 0; c < 8 && c < b_obs.size(); c++)
            chk("t3_item", b_obs[c], exp_b(8'h00, c, c == 7));
        b_in_valid = 1'b1; b_in_sof = 1'b0; b_in_data = 8'h77;
        @(negedge clk);
        chk("t3_ovf_nowr", b_lb0_wr_en, 1'b0);
        chk("t3_ovf_pre", b_ovf_err, 1'b0);
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        chk("t3_ovf", b_ovf_err, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_ovf_end", b_ovf_err, 1'b0);
        @(posedge clk); #1;
        chk("t3_no_out", b_obs.size(), 8);

        // restart at row 2 col 3
        b_obs.delete();
        frame(1'b1, 8, 0, 2, 3, 8'h00, 1'b0);
        frame(1'b1, 8, 0, 1, 8, 8'h80, 1'b0);
        idle(4);
        chk("t4_quiet", b_obs.size(), 3);
        frame(1'b1, 8, 2, 2, 8, 8'h80, 1'b0);
        idle(5);
        chk("t4_count", b_obs.size(), 11);
        for (int k = 0; k < 3 && k < b_obs.size(); k++)
            chk("t4_old", b_obs[k], exp_b(8'h00, k, 1'b0));
        for (int c = 0; c < 8 && 3 + c < b_obs.size(); c++)
            chk("t4_new", b_obs[3 + c], exp_b(8'h80, c, c == 7));

        // reset mid-row with pixels in flight
        b_obs.delete();
        frame(1'b1, 8, 0, 2, 5, 8'h00, 1'b0);
        b_in_valid = 1'b1; b_in_sof = 1'b0; b_in_data = 8'h25;
        rst = 1'b1;
        @(posedge clk); #1;
        idle(0);
        @(negedge clk);
        chk("t5_rst_out", {b_out_valid, b_out_top, b_out_mid, b_out_bot, b_out_col,
                           b_out_eol, b_out_eof, b_ovf_err}, '0);
        chk("t5_rst_lb", {b_lb0_addr, b_lb0_wr_en, b_lb0_rd_en, b_lb0_wdata,
                          b_lb1_addr, b_lb1_wr_en, b_lb1_rd_en, b_lb1_wdata}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        b_in_valid = 1'b1; b_in_sof = 1'b0; b_in_data = 8'h26;
        @(negedge clk);
        chk("t5_drop", b_lb0_wr_en, 1'b0);
        @(posedge clk); #1;
        idle(5);
        chk("t5_count", b_obs.size(), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
